// File: rtl/gpio_cfg_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cfg_pkg
// Shared definitions for the GPIO configuration serializer:
//   - state_t       : serializer FSM states
//   - CFG_BITS      : configuration bits per pad
//   - CFG_*         : bit positions of the fields inside one pad config word
// -----------------------------------------------------------------------------
package gpio_cfg_pkg;

  localparam int CFG_BITS = 13;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SHIFT,
    LOAD,
    DONE
  } state_t;

  // Field positions inside a pad configuration word.
  localparam int CFG_MGMT_EN     = 0;
  localparam int CFG_OEB         = 1;
  localparam int CFG_HOLDOVER    = 2;
  localparam int CFG_INP_DIS     = 3;
  localparam int CFG_IB_MODE_SEL = 4;
  localparam int CFG_ANALOG_EN   = 5;
  localparam int CFG_ANALOG_SEL  = 6;
  localparam int CFG_ANALOG_POL  = 7;
  localparam int CFG_SLOW        = 8;
  localparam int CFG_VTRIP       = 9;
  localparam int CFG_DM_LSB      = 10;
  localparam int CFG_DM_MSB      = 12;

endpackage

// File: rtl/gpio_cfg_tick.sv
// -----------------------------------------------------------------------------
// gpio_cfg_tick
// Phase counter for one serial bit period of CLK_DIV system clocks.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_clear               : restart the period (next cycle is phase 0)
//   i_en                  : advance the counter
//   o_phase_low_start     : current cycle is the first cycle of the low phase
//   o_phase_high_start    : current cycle is the last low cycle; a register
//                           updated on this edge is high from the next cycle
//   o_bit_end             : current cycle is the last cycle of the period
// -----------------------------------------------------------------------------
module gpio_cfg_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_phase_low_start,
  output logic o_phase_high_start,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_phase_low_start  = (r_cnt == '0);
  assign o_phase_high_start = (r_cnt == CNT_W'(CLK_DIV / 2 - 1));
  assign o_bit_end          = (r_cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/gpio_cfg_serializer.sv
// -----------------------------------------------------------------------------
// gpio_cfg_serializer
// Reads one configuration word per GPIO pad from the housekeeping store and
// shifts them, MSB first, into the two GPIO control-block daisy chains in
// parallel, then pulses the chain load strobe so every pad updates at once.
// Ports:
//   wb_clk_i, wb_rstn_i        : clock, asynchronous active-low reset
//   start                      : one-cycle request, honoured only when idle
//   busy, done                 : transfer in progress / one-cycle end pulse
//   cfg_rd                     : config-store read strobe
//   cfg_idx_1, cfg_idx_2       : pad index requested for chain 1 / chain 2
//   cfg_word_1, cfg_word_2     : returned words, valid the cycle after cfg_rd
//   serial_clock               : chain shift clock (chains sample on rise)
//   serial_load                : chain load strobe
//   serial_resetn              : chain reset, active low
//   serial_data_1/2            : chain 1 / chain 2 data
// -----------------------------------------------------------------------------
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif
`ifndef MPRJ_IO_PADS_1
`define MPRJ_IO_PADS_1 19
`endif

module gpio_cfg_serializer #(
  parameter int TOTAL_PADS = `MPRJ_IO_PADS,
  parameter int AREA1PADS  = `MPRJ_IO_PADS_1,
  parameter int CFG_BITS   = gpio_cfg_pkg::CFG_BITS,
  parameter int CLK_DIV    = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rstn_i,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_rd,
  output logic [$clog2(TOTAL_PADS)-1:0] cfg_idx_1,
  output logic [$clog2(TOTAL_PADS)-1:0] cfg_idx_2,
  input  logic [CFG_BITS-1:0]           cfg_word_1,
  input  logic [CFG_BITS-1:0]           cfg_word_2,
  output logic                          serial_clock,
  output logic                          serial_load,
  output logic                          serial_resetn,
  output logic                          serial_data_1,
  output logic                          serial_data_2
);

  import gpio_cfg_pkg::*;

  localparam int IDX_W = $clog2(TOTAL_PADS);
  localparam int N     = AREA1PADS;
  localparam int BIT_W = $clog2(CFG_BITS + 1);

  generate
    if ((TOTAL_PADS - AREA1PADS) != AREA1PADS) begin : g_bad_split
      $error("gpio_cfg_serializer: both chains must have the same length");
    end
    if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
      $error("gpio_cfg_serializer: CLK_DIV must be even and at least 2");
    end
  endgenerate

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_cfg_rd;
  logic                r_sclk;
  logic                r_load;
  logic                r_srstn;
  logic [IDX_W-1:0]    r_idx1;
  logic [IDX_W-1:0]    r_idx2;
  logic [IDX_W-1:0]    r_k;
  logic [BIT_W-1:0]    r_bit;
  logic [CFG_BITS-1:0] r_sr1;
  logic [CFG_BITS-1:0] r_sr2;

  logic w_low_start;
  logic w_high_start;
  logic w_bit_end;
  logic w_tick_en;
  logic w_tick_clear;
  logic w_word_end;
  logic w_last_word;

  // r_bit counts bits already started, so it equals CFG_BITS during the
  // final bit of a word.
  assign w_word_end   = (r_state == SHIFT) && w_bit_end && (r_bit == BIT_W'(CFG_BITS));
  assign w_last_word  = (r_k == IDX_W'(N - 1));
  assign w_tick_en    = (r_state == SHIFT) || (r_state == LOAD);
  assign w_tick_clear = (r_state == LATCH) || (w_word_end && w_last_word);

  gpio_cfg_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk              (wb_clk_i),
    .i_rst_n            (wb_rstn_i),
    .i_clear            (w_tick_clear),
    .i_en               (w_tick_en),
    .o_phase_low_start  (w_low_start),
    .o_phase_high_start (w_high_start),
    .o_bit_end          (w_bit_end)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cfg_rd <= 1'b0;
      r_sclk   <= 1'b0;
      r_load   <= 1'b0;
      r_srstn  <= 1'b0;
      r_idx1   <= '0;
      r_idx2   <= '0;
      r_k      <= '0;
      r_bit    <= '0;
      r_sr1    <= '0;
      r_sr2    <= '0;
    end else begin
      r_srstn <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FETCH;
            r_busy   <= 1'b1;
            r_cfg_rd <= 1'b1;
            r_k      <= '0;
            // Chain 1 is filled far-end first; chain 2 starts at pad AREA1PADS.
            r_idx1   <= IDX_W'(N - 1);
            r_idx2   <= IDX_W'(N);
          end
        end
        FETCH: begin
          r_cfg_rd <= 1'b0;
          r_state  <= LATCH;
        end
        LATCH: begin
          r_sr1   <= cfg_word_1;
          r_sr2   <= cfg_word_2;
          r_bit   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_low_start) begin
            r_bit <= r_bit + 1'b1;
          end
          if (w_high_start) begin
            r_sclk <= 1'b1;
          end
          if (w_bit_end) begin
            r_sclk <= 1'b0;
            if (w_word_end) begin
              if (w_last_word) begin
                r_load  <= 1'b1;
                r_state <= LOAD;
              end else begin
                r_k      <= r_k + 1'b1;
                r_idx1   <= r_idx1 - 1'b1;
                r_idx2   <= r_idx2 + 1'b1;
                r_cfg_rd <= 1'b1;
                r_state  <= FETCH;
              end
            end else begin
              // Next bit appears on the first low-phase cycle of its period.
              r_sr1 <= {r_sr1[CFG_BITS-2:0], 1'b0};
              r_sr2 <= {r_sr2[CFG_BITS-2:0], 1'b0};
            end
          end
        end
        LOAD: begin
          if (w_high_start) begin
            r_load <= 1'b0;
          end
          if (w_bit_end) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign cfg_rd        = r_cfg_rd;
  assign cfg_idx_1     = r_idx1;
  assign cfg_idx_2     = r_idx2;
  assign serial_clock  = r_sclk;
  assign serial_load   = r_load;
  assign serial_resetn = r_srstn;
  assign serial_data_1 = r_sr1[CFG_BITS-1];
  assign serial_data_2 = r_sr2[CFG_BITS-1];

endmodule
